riscv_soft_imm_stage: RTL and testbench
=======================================

# riscv_soft_imm_stage

Pipelined, parametrised immediate-generation stage for the riscv-soft decode path. Accepts a 32-bit instruction word, an immediate-format select and a sideband tag over a valid/ready handshake, and produces the XPR_LEN-wide sign- or zero-extended immediate one cycle later. A 2-entry skid buffer gives full throughput under backpressure. Over the base I/S/B/U/J formats it adds CSR zimm and shift-amount formats, RV64 widths, an illegal-select flag and a synchronous flush.

## Interface
- XPR_LEN, 32: output immediate width; legal values are 32 and 64 only.
- TAG_W, 4: width of the sideband tag carried alongside each instruction.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous drop of all buffered entries.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept; driven directly from a register.
- in_inst  input  32  instruction word.
- in_imm_sel  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6=SH (shamt), 7=illegal.
- in_tag  input  TAG_W  opaque sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_imm  output  XPR_LEN  generated immediate.
- out_tag  output  TAG_W  tag of the result.
- out_illegal  output  1  asserted with a result whose select was 7.

## Operation
- Input transfer occurs on a cycle with in_valid && in_ready. Output transfer occurs on a cycle with out_valid && out_ready.
- Immediate is computed combinationally from in_inst and registered at entry write. Entries store imm, tag and illegal.
- Format rules; "sext" means sign-extend to XPR_LEN:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: sext({inst[31:12], 12'b0}); in RV32 this is an identity.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Z: zero-extend inst[19:15].
  - SH: zero-extend inst[25:20] when XPR_LEN=64, otherwise inst[24:20].
  - Select 7: imm=0 and illegal=1. All other selects give illegal=0.
- Buffer is a 2-entry FIFO, entries HEAD and SKID.
- State machine:
  - States are EMPTY, ONE and FULL.
  - EMPTY→ONE on an input transfer.
  - ONE→FULL on an input transfer without an output transfer.
  - ONE→EMPTY on an output transfer without an input transfer.
  - ONE→ONE on both (HEAD is replaced by the new entry).
  - FULL→ONE on an output transfer (SKID moves to HEAD). No input is accepted in FULL.
- in_ready = (state != FULL), registered from next-state.
- out_valid = (state != EMPTY); out_imm, out_tag and out_illegal always reflect HEAD.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated except by flush or reset.
- flush: next state is EMPTY. Any input presented in the same cycle is discarded. Output transfer in that cycle still counts as completed if out_ready was high.
- reset overrides flush and all transfers.

## Timing
- Latency: input accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY, or when it was ONE and HEAD transferred in cycle N.
- Throughput is one result per cycle when out_ready is held high.
- in_ready falls in the cycle after the second entry is stored while out_ready is low. It rises in the cycle after the first output transfer from FULL.
- out_* remain stable while out_valid && !out_ready.
- Reset values, present in the cycle after reset is sampled high:
  - state=EMPTY, in_ready=1, out_valid=0.
  - out_imm=0, out_tag=0, out_illegal=0.
- Reset mid-operation discards all entries.
- A flush in FULL makes in_ready=1 on the next cycle.

## Test plan
- Formats, XPR_LEN=32:
  - I, 0xFFF00093 → 0xFFFFFFFF.
  - S, 0xFE20AE23 → 0xFFFFFFFC.
  - B, 0xFE000CE3 → 0xFFFFFFF8.
  - U, 0x123450B7 → 0x12345000.
  - Z, 0x000F8073 → 0x0000001F.
  - Select 7 → imm 0 with out_illegal=1.
- XPR_LEN=64:
  - U, 0x800000B7 → 0xFFFFFFFF80000000.
  - SH, 0x03F01013 → 0x3F; the same instruction at XPR_LEN=32 → 0x1F.
- Streaming: 8 back-to-back requests, out_ready=1, tags 0..7 → 8 results on consecutive cycles, in order, first result one cycle after the first accept.
- Backpressure:
  - Hold out_ready=0 and offer 3 requests (tags 1, 2, 3) → tags 1 and 2 are accepted, in_ready=0, tag 3 stalls and out_* hold tag 1.
  - Release out_ready → results 1, 2, 3 in order with no bubble after tag 1.
- Flush: in FULL, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed and concurrent entries never appear.
- Reset: assert reset while FULL and out_ready=0 → next cycle all outputs equal their reset values and in_ready=1. The first request after reset emerges with a correct immediate.

Source files
------------

// File: rtl/riscv_soft_imm_stage.sv
// riscv_soft_imm_stage: RISC-V immediate generator with a registered 2-entry skid buffer on a valid/ready path.
module riscv_soft_imm_stage #(
    parameter int XPR_LEN = 32,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [2:0]         in_imm_sel,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XPR_LEN-1:0] out_imm,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state_q, state_d;
    logic in_ready_q;
    logic [XPR_LEN-1:0] head_imm_q, head_imm_d, skid_imm_q, skid_imm_d, new_imm;
    logic [TAG_W-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;
    logic head_ill_q, head_ill_d, skid_ill_q, skid_ill_d, new_ill;
    logic [31:0] raw;
    logic in_fire, out_fire, load_head, load_skid;
    logic unused_opcode;
    assign unused_opcode = ^in_inst[6:0];
    // Every format yields a 32-bit value whose bit 31 is the correct extension bit,
    // so a single sign extension covers both sext and zext formats.
    always_comb begin
        case (in_imm_sel)
            3'd0:    raw = {{20{in_inst[31]}}, in_inst[31:20]};
            3'd1:    raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'd2:    raw = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            3'd3:    raw = {in_inst[31:12], 12'b0};
            3'd4:    raw = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            3'd5:    raw = {27'b0, in_inst[19:15]};
            3'd6:    raw = {26'b0, (XPR_LEN == 64) ? in_inst[25] : 1'b0, in_inst[24:20]};
            default: raw = 32'b0;
        endcase
    end
    assign new_imm   = XPR_LEN'($signed(raw));
    assign new_ill   = in_imm_sel == 3'd7;
    assign in_fire   = in_valid && in_ready_q && !flush;
    assign out_fire  = (state_q != EMPTY) && out_ready;
    always_comb begin
        state_d = state_q;
        if (flush) state_d = EMPTY;
        else case (state_q)
            EMPTY:   state_d = in_fire ? ONE : EMPTY;
            ONE:     state_d = (in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE;
            FULL:    state_d = out_fire ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
    end
    always_comb begin
        load_head  = (state_q == EMPTY && in_fire) || (state_q == ONE && in_fire && out_fire) || (state_q == FULL && out_fire);
        load_skid  = state_q == ONE && in_fire && !out_fire;
        head_imm_d = !load_head ? head_imm_q : (state_q == FULL) ? skid_imm_q : new_imm;
        head_tag_d = !load_head ? head_tag_q : (state_q == FULL) ? skid_tag_q : in_tag;
        head_ill_d = !load_head ? head_ill_q : (state_q == FULL) ? skid_ill_q : new_ill;
        skid_imm_d = load_skid ? new_imm : skid_imm_q;
        skid_tag_d = load_skid ? in_tag : skid_tag_q;
        skid_ill_d = load_skid ? new_ill : skid_ill_q;
    end
    always_comb begin
        in_ready    = in_ready_q;
        out_valid   = state_q != EMPTY;
        out_imm     = head_imm_q;
        out_tag     = head_tag_q;
        out_illegal = head_ill_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != FULL;
            head_imm_q <= head_imm_d;
            head_tag_q <= head_tag_d;
            head_ill_q <= head_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end
endmodule

// File: tb/tb_riscv_soft_imm_stage.sv
// tb_riscv_soft_imm_stage: directed vectors on RV32 and RV64 instances driven in lockstep.
module tb_riscv_soft_imm_stage;
    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [2:0] in_imm_sel;
    logic [3:0] in_tag;
    logic in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [3:0] out_tag;
    logic r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [63:0] r64_out_imm;
    logic [3:0] r64_out_tag;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_soft_imm_stage #(.XPR_LEN(32), .TAG_W(4)) u_rv32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    riscv_soft_imm_stage #(.XPR_LEN(64), .TAG_W(4)) u_rv64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(r64_out_valid),
        .out_ready(out_ready), .out_imm(r64_out_imm), .out_tag(r64_out_tag), .out_illegal(r64_out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] sel, input logic [31:0] inst, input logic [3:0] tag);
        in_valid = 1'b1;
        in_imm_sel = sel;
        in_inst = inst;
        in_tag = tag;
    endtask

    task automatic send_one(input string name, input logic [2:0] sel, input logic [31:0] inst,
                            input logic [3:0] tag, input logic [63:0] exp32, input logic [63:0] exp64,
                            input logic exp_ill);
        out_ready = 1'b1;
        offer(sel, inst, tag);
        step();
        in_valid = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_imm32"}, 64'(out_imm), exp32);
        check({name, "_imm64"}, r64_out_imm, exp64);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_ill"}, 64'(out_illegal), 64'(exp_ill));
        step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_imm_sel = '0; in_tag = '0;
        step();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_ill", 64'(out_illegal), 64'd0);

        send_one("fmt_i", 3'd0, 32'hFFF00093, 4'h1, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        send_one("fmt_s", 3'd1, 32'hFE20AE23, 4'h2, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        send_one("fmt_b", 3'd2, 32'hFE000CE3, 4'h3, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
        send_one("fmt_u", 3'd3, 32'h123450B7, 4'h4, 64'h12345000, 64'h12345000, 1'b0);
        send_one("fmt_j", 3'd4, 32'hFFDFF06F, 4'h5, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        send_one("fmt_z", 3'd5, 32'h000F8073, 4'h6, 64'h1F, 64'h1F, 1'b0);
        send_one("fmt_ill", 3'd7, 32'hFFFFFFFF, 4'h7, 64'h0, 64'h0, 1'b1);
        send_one("fmt_u_neg", 3'd3, 32'h800000B7, 4'h8, 64'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
        send_one("fmt_sh", 3'd6, 32'h03F01013, 4'h9, 64'h1F, 64'h3F, 1'b0);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", 64'(in_ready), 64'd1);
            offer(3'd0, {12'(i), 20'h00093}, 4'(i));
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_tag", 64'(out_tag), 64'(i));
            check("stream_imm", 64'(out_imm), 64'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        offer(3'd0, 32'h00100093, 4'd1);
        step();
        check("bp_ready_one", 64'(in_ready), 64'd1);
        offer(3'd0, 32'h00200093, 4'd2);
        step();
        check("bp_ready_full", 64'(in_ready), 64'd0);
        offer(3'd0, 32'h00300093, 4'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_tag", 64'(out_tag), 64'd1);
            check("bp_hold_imm", 64'(out_imm), 64'd1);
        end
        out_ready = 1'b1;
        step();
        check("bp_rel_tag2", 64'(out_tag), 64'd2);
        check("bp_rel_imm2", 64'(out_imm), 64'd2);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_rel_tag3", 64'(out_tag), 64'd3);
        check("bp_rel_valid3", 64'(out_valid), 64'd1);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        offer(3'd0, 32'h00400093, 4'd4);
        step();
        offer(3'd0, 32'h00500093, 4'd5);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        offer(3'd0, 32'h00600093, 4'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_stays_empty", 64'(out_valid), 64'd0);
        send_one("fl_next", 3'd0, 32'h00700093, 4'd7, 64'd7, 64'd7, 1'b0);

        out_ready = 1'b0;
        offer(3'd0, 32'h00800093, 4'd8);
        step();
        offer(3'd0, 32'h00900093, 4'd9);
        step();
        check("rs_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rs_in_ready", 64'(in_ready), 64'd1);
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_imm", 64'(out_imm), 64'd0);
        check("rs_tag", 64'(out_tag), 64'd0);
        check("rs_ill", 64'(out_illegal), 64'd0);
        send_one("rs_next", 3'd0, 32'hFFF00093, 4'hA, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
